ball_frame_tx: RTL and testbench

BALL_FRAME_TX -- requirements
Module: ball_frame_tx

---
 rtl/ball_frame_tx_if.sv | 19 +
 rtl/ball_frame_tx.sv | 82 ++++++++
 tb/tb_ball_frame_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ball_frame_tx_if.sv
// ball_frame_tx_if: byte-stream handshake between the frame sender and the I2C master
interface ball_frame_tx_if;
  logic       tx_start;
  logic [6:0] tx_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       is_i2c_master_done;
  logic       i2c_nack;
  modport master (
    output tx_start, tx_addr, tx_data, tx_valid, tx_last,
    input  tx_ready, is_i2c_master_done, i2c_nack
  );
  modport slave (
    input  tx_start, tx_addr, tx_data, tx_valid, tx_last,
    output tx_ready, is_i2c_master_done, i2c_nack
  );
endinterface

// File: rtl/ball_frame_tx.sv
// ball_frame_tx: sends a 5-byte ball hand-off frame over I2C with NACK retry, timeout and one-deep pending request
module ball_frame_tx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
  parameter int         MAX_RETRY   = 2,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                  clk_25MHZ,
  input  logic                  reset,
  input  logic                  ball_send_trigger,
  input  logic [9:0]            ball_y,
  input  logic [7:0]            ball_vy,
  input  logic [1:0]            gravity_counter,
  input  logic [9:0]            estimated_speed,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_err,
  ball_frame_tx_if.master       bus
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, START, SEND, WAIT_DONE, DONE, ERR} state_t;
  state_t          state, state_n;
  logic [7:0]      frame [5];
  logic [2:0]      idx;
  logic [RW-1:0]   retry_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            pending, acc, tmo, retry_ok, go;
  assign acc      = state == SEND && bus.tx_ready;
  assign tmo      = tmo_cnt == TW'(TIMEOUT_CYC - 1);
  assign retry_ok = retry_cnt < RW'(MAX_RETRY);
  assign go       = ball_send_trigger || pending;
  assign bus.tx_addr  = SLAVE_ADDR;
  assign bus.tx_valid = state == SEND;
  assign bus.tx_last  = state == SEND && idx == 3'd4;
  assign bus.tx_data  = state == SEND ? frame[idx] : 8'h00;
  assign tx_busy = state != IDLE;
  assign tx_done = state == DONE;
  assign tx_err  = state == ERR;
  // next state: an accepted byte beats a coinciding timeout, a done pulse beats a coinciding timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = go ? START : IDLE;
      START:     state_n = SEND;
      SEND:      state_n = acc ? (idx == 3'd4 ? WAIT_DONE : SEND) : (tmo ? ERR : SEND);
      WAIT_DONE: state_n = bus.is_i2c_master_done ? (!bus.i2c_nack ? DONE : retry_ok ? START : ERR)
                                                  : (tmo ? ERR : WAIT_DONE);
      default:   state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk_25MHZ or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;
  // frame latch, byte index, retry and timeout counters, pending flag and start pulse
  always_ff @(posedge clk_25MHZ or negedge reset) begin
    if (!reset) begin
      frame        <= '{default: 8'h00};
      idx          <= '0;
      retry_cnt    <= '0;
      tmo_cnt      <= '0;
      pending      <= 1'b0;
      bus.tx_start <= 1'b0;
    end else begin
      bus.tx_start <= state == START;
      pending      <= state != IDLE && (pending || ball_send_trigger);
      if (state == IDLE && go) begin
        frame[0]  <= ball_y[7:0];
        frame[1]  <= {6'b0, ball_y[9:8]};
        frame[2]  <= ball_vy;
        frame[3]  <= {6'b0, gravity_counter};
        frame[4]  <= estimated_speed > 10'd255 ? 8'hFF : estimated_speed[7:0];
        retry_cnt <= '0;
      end else if (state == WAIT_DONE && state_n == START) begin
        retry_cnt <= retry_cnt + RW'(1);
      end
      idx     <= state == START ? 3'd0 : idx + 3'(acc);
      tmo_cnt <= (state_n != state || acc) ? '0
               : (state == SEND || state == WAIT_DONE) ? tmo_cnt + TW'(1) : tmo_cnt;
    end
  end
endmodule

// File: tb/tb_ball_frame_tx.sv
// tb_ball_frame_tx: directed checks of framing, backpressure, retry, timeout, pending and reset
module tb_ball_frame_tx;
  logic       clk = 0, rst_n = 0, trig = 0;
  logic [9:0] by = '0, es = '0;
  logic [7:0] bvy = '0;
  logic [1:0] gc = '0;
  logic       busy, done, err;
  int compared = 0, mism = 0, nstart = 0, ndone = 0, nerr = 0;
  int s0, d0, e0;
  logic [7:0] got[$];
  logic       lastq[$];
  ball_frame_tx_if bus();
  ball_frame_tx #(.TIMEOUT_CYC(20)) dut (
    .clk_25MHZ(clk), .reset(rst_n), .ball_send_trigger(trig), .ball_y(by), .ball_vy(bvy),
    .gravity_counter(gc), .estimated_speed(es), .tx_busy(busy), .tx_done(done), .tx_err(err),
    .bus(bus)
  );
  always #10 clk = ~clk;
  // record transferred bytes and count pulses just after each falling edge
  always begin
    @(negedge clk);
    #2;
    if (bus.tx_valid && bus.tx_ready) begin
      got.push_back(bus.tx_data);
      lastq.push_back(bus.tx_last);
    end
    if (bus.tx_start) nstart++;
    if (done) ndone++;
    if (err) nerr++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic trigger();
    trig = 1;
    cyc();
    trig = 0;
  endtask
  task automatic wait_bytes(input int n);
    int k = 0;
    while (got.size() < n && k < 60) begin
      cyc();
      k++;
    end
    if (got.size() < n) chk("byte_wait", got.size(), n);
  endtask
  task automatic ack(input logic nack);
    bus.is_i2c_master_done = 1;
    bus.i2c_nack = nack;
    cyc();
    bus.is_i2c_master_done = 0;
    bus.i2c_nack = 0;
  endtask
  task automatic chk_frame(input string tag, input int base, input logic [39:0] e);
    for (int i = 0; i < 5; i++) chk(tag, {24'h0, got[base+i]}, {24'h0, e[39-8*i -: 8]});
  endtask
  task automatic clear();
    got.delete();
    lastq.delete();
    s0 = nstart;
    d0 = ndone;
    e0 = nerr;
  endtask
  initial begin
    bus.tx_ready = 0;
    bus.is_i2c_master_done = 0;
    bus.i2c_nack = 0;
    repeat (3) cyc();
    chk("rst_outs", {busy, done, err, bus.tx_start, bus.tx_valid, bus.tx_last, bus.tx_data}, 0);
    chk("addr", bus.tx_addr, 7'h2A);
    rst_n = 1;
    cyc();
    ack(0);
    cyc();
    chk("done_in_idle", {busy, done, err}, 0);
    // basic frame
    clear();
    by = 10'h2C5; bvy = 8'hFD; gc = 2'b10; es = 10'h12C; bus.tx_ready = 1;
    trigger();
    chk("start_lat1", {bus.tx_start, busy}, 2'b01);
    cyc();
    chk("start_lat2", {bus.tx_start, bus.tx_valid, bus.tx_last}, 3'b110);
    chk("byte0", bus.tx_data, 8'hC5);
    cyc();
    chk("start_once", bus.tx_start, 0);
    wait_bytes(5);
    chk("wait_done_state", {busy, bus.tx_valid}, 2'b10);
    ack(0);
    chk("basic_done", {done, err}, 2'b10);
    chk_frame("basic", 0, 40'hC502FD02FF);
    chk("basic_last", {lastq[0], lastq[1], lastq[2], lastq[3], lastq[4]}, 5'b00001);
    cyc();
    chk("basic_idle", {busy, done}, 0);
    chk("basic_ndone", ndone - d0, 1);
    // backpressure on byte2, input changes mid-frame ignored
    clear();
    by = 10'h13A; bvy = 8'h05; gc = 2'b01; es = 10'h0FE;
    trigger();
    by = 10'h3FF; bvy = 8'h00; gc = 2'b00; es = 10'h000;
    cyc();
    cyc();
    cyc();
    bus.tx_ready = 0;
    chk("bp_b2", {bus.tx_valid, bus.tx_data}, 9'h105);
    repeat (3) begin
      cyc();
      chk("bp_hold", {bus.tx_valid, bus.tx_data}, 9'h105);
    end
    bus.tx_ready = 1;
    wait_bytes(5);
    ack(0);
    chk("bp_done", done, 1);
    cyc();
    chk("bp_count", got.size(), 5);
    chk_frame("bp", 0, 40'h3A010501FE);
    // two NACKs then ACK: three identical frames, saturating speed boundary
    clear();
    by = 10'h2C5; bvy = 8'hFD; gc = 2'b10; es = 10'h100;
    trigger();
    by = 10'h000; es = 10'h000;
    wait_bytes(5);
    ack(1);
    wait_bytes(10);
    ack(1);
    wait_bytes(15);
    ack(0);
    chk("retry_done", {done, err}, 2'b10);
    chk_frame("retry_f0", 0, 40'hC502FD02FF);
    chk_frame("retry_f1", 5, 40'hC502FD02FF);
    chk_frame("retry_f2", 10, 40'hC502FD02FF);
    cyc();
    chk("retry_starts", nstart - s0, 3);
    chk("retry_ndone", ndone - d0, 1);
    chk("retry_nerr", nerr - e0, 0);
    // three NACKs: abandoned
    clear();
    trigger();
    wait_bytes(5);
    ack(1);
    wait_bytes(10);
    ack(1);
    wait_bytes(15);
    ack(1);
    chk("nack3_err", {err, done}, 2'b10);
    cyc();
    chk("nack3_ndone", ndone - d0, 0);
    chk("nack3_nerr", nerr - e0, 1);
    chk("nack3_idle", busy, 0);
    // timeout with tx_ready held low
    clear();
    bus.tx_ready = 0;
    trigger();
    cyc();
    chk("to_send", bus.tx_valid, 1);
    repeat (19) cyc();
    chk("to_before", {err, busy}, 2'b01);
    cyc();
    chk("to_err", err, 1);
    cyc();
    chk("to_idle", {busy, bus.tx_valid, err}, 0);
    chk("to_counts", {nerr - e0, ndone - d0}, {32'd1, 32'd0});
    bus.tx_ready = 1;
    // pending: two triggers during byte1 merge into one extra frame
    clear();
    by = 10'h2C5; bvy = 8'hFD; gc = 2'b10; es = 10'h12C;
    trigger();
    cyc();
    cyc();
    trig = 1; by = 10'h001; bus.tx_ready = 0;
    chk("pend_b1", bus.tx_data, 8'h02);
    cyc();
    trig = 0;
    cyc();
    trig = 1; bus.tx_ready = 1;
    cyc();
    trig = 0;
    wait_bytes(5);
    ack(0);
    chk("pend_done1", done, 1);
    wait_bytes(10);
    ack(0);
    chk("pend_done2", done, 1);
    repeat (10) cyc();
    chk("pend_starts", nstart - s0, 2);
    chk("pend_ndone", ndone - d0, 2);
    chk("pend_idle", busy, 0);
    chk_frame("pend_f1", 0, 40'hC502FD02FF);
    chk_frame("pend_f2", 5, 40'h0100FD02FF);
    // reset during byte3
    clear();
    trigger();
    repeat (4) cyc();
    chk("rst_b3", {bus.tx_valid, bus.tx_data}, 9'h102);
    rst_n = 0;
    #1;
    chk("rst_async", {busy, done, err, bus.tx_start, bus.tx_valid, bus.tx_last, bus.tx_data}, 0);
    cyc();
    rst_n = 1;
    repeat (3) cyc();
    chk("rst_wait", busy, 0);
    chk("rst_no_pulse", {ndone - d0, nerr - e0}, 0);
    clear();
    trigger();
    wait_bytes(5);
    ack(0);
    chk("rst_frame_done", done, 1);
    cyc();
    chk("rst_frame_len", got.size(), 5);
    chk_frame("rst_frame", 0, 40'h0100FD02FF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
